// File: rtl/alu_issue_pkg.sv
// Shared opcodes, FSM encoding and instruction field offsets for the ALU issue controller.
package alu_issue_pkg;

   localparam logic [3:0] OP_ADD = 4'h0;
   localparam logic [3:0] OP_SUB = 4'h1;
   localparam logic [3:0] OP_INC = 4'h2;
   localparam logic [3:0] OP_DEC = 4'h3;
   localparam logic [3:0] OP_AND = 4'h4;
   localparam logic [3:0] OP_OR  = 4'h5;
   localparam logic [3:0] OP_XOR = 4'h6;
   localparam logic [3:0] OP_SHL = 4'h7;
   localparam logic [3:0] OP_SHR = 4'h8;
   localparam logic [3:0] OP_CMP = 4'h9;
   localparam logic [3:0] OP_LDI = 4'hA;

   localparam int OPCODE_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_WB   = 2'd2
   } state_e;

   // Field LSB positions; layout MSB first is op | rd | rs1 | low field (rs2 at its top).
   function automatic int op_lsb(input int dw, input int aw);
      return dw + 2 * aw;
   endfunction

   function automatic int rd_lsb(input int dw, input int aw);
      return dw + aw;
   endfunction

   function automatic int rs1_lsb(input int dw);
      return dw;
   endfunction

   function automatic int rs2_lsb(input int dw, input int aw);
      return dw - aw;
   endfunction

   function automatic logic op_writes_reg(input logic [3:0] op);
      return (op <= OP_SHR) || (op == OP_LDI);
   endfunction

endpackage

// File: rtl/alu_issue_regfile.sv
// Register file: async-reset storage, one write port, three combinational read ports.
module alu_issue_regfile
   import alu_issue_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int REG_ADDR_W = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  we_i,
   input  logic [REG_ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0]     wdata_i,
   input  logic [REG_ADDR_W-1:0] raddr1_i,
   input  logic [REG_ADDR_W-1:0] raddr2_i,
   input  logic [REG_ADDR_W-1:0] dbg_addr_i,
   output logic [DATA_W-1:0]     rdata1_o,
   output logic [DATA_W-1:0]     rdata2_o,
   output logic [DATA_W-1:0]     dbg_data_o
);

   localparam int NREG = 2 ** REG_ADDR_W;

   logic [DATA_W-1:0] mem_q [NREG];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata1_o   = mem_q[raddr1_i];
   assign rdata2_o   = mem_q[raddr2_i];
   assign dbg_data_o = mem_q[dbg_addr_i];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the 8-bit ALU: IDLE -> EXEC -> WB per instruction.
// Define ALU_ISSUE_OVERLAP_EN to accept in WB and forward the written value.
module alu_issue_ctrl
   import alu_issue_pkg::*;
#(
   parameter int         DATA_W     = 8,
   parameter int         REG_ADDR_W = 2,
   parameter logic [3:0] IDLE_OP    = 4'hF
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                instr_valid,
   output logic                                instr_ready,
   input  logic [OPCODE_W+2*REG_ADDR_W+DATA_W-1:0] instr,
   output logic [DATA_W-1:0]                   alu_operand1,
   output logic [DATA_W-1:0]                   alu_operand2,
   output logic [3:0]                          alu_op,
   input  logic [DATA_W-1:0]                   alu_result,
   input  logic                                alu_zero,
   output logic                                wb_valid,
   output logic [REG_ADDR_W-1:0]               wb_addr,
   output logic [DATA_W-1:0]                   wb_data,
   output logic                                eq_flag,
   output logic                                illegal_op,
   input  logic [REG_ADDR_W-1:0]               dbg_addr,
   output logic [DATA_W-1:0]                   dbg_data
);

   localparam int INSTR_W = OPCODE_W + 2 * REG_ADDR_W + DATA_W;
   localparam int OP_LSB  = op_lsb(DATA_W, REG_ADDR_W);
   localparam int RD_LSB  = rd_lsb(DATA_W, REG_ADDR_W);
   localparam int RS1_LSB = rs1_lsb(DATA_W);
   localparam int RS2_LSB = rs2_lsb(DATA_W, REG_ADDR_W);

   state_e               state_q, state_d;
   logic [INSTR_W-1:0]   instr_q, instr_d;
   logic [DATA_W-1:0]    res_q, res_d;
   logic                 zq_q, zq_d;
   logic                 eq_q, eq_d;

   logic [3:0]            op_s;
   logic [REG_ADDR_W-1:0] rd_s, rs1_s, rs2_s;
   logic [DATA_W-1:0]     imm_s, rdata1_s, rdata2_s, opnd1_s, opnd2_s;
   logic                  hs_s, we_s;

   assign op_s  = instr_q[OP_LSB +: OPCODE_W];
   assign rd_s  = instr_q[RD_LSB +: REG_ADDR_W];
   assign rs1_s = instr_q[RS1_LSB +: REG_ADDR_W];
   assign rs2_s = instr_q[RS2_LSB +: REG_ADDR_W];
   assign imm_s = instr_q[DATA_W-1:0];

`ifdef ALU_ISSUE_OVERLAP_EN
   logic                  fwd_q, fwd_d;
   logic [REG_ADDR_W-1:0] fwd_rd_q, fwd_rd_d;

   assign instr_ready = rst_n && ((state_q == ST_IDLE) || (state_q == ST_WB));
   assign fwd_d       = (state_q == ST_WB) && hs_s && op_writes_reg(op_s);
   assign fwd_rd_d    = rd_s;
   // res_q still holds the previous result during the EXEC that follows its WB.
   assign opnd1_s     = (fwd_q && (rs1_s == fwd_rd_q)) ? res_q : rdata1_s;
   assign opnd2_s     = (fwd_q && (rs2_s == fwd_rd_q)) ? res_q : rdata2_s;

   // Forwarding tag for the instruction accepted during WB.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fwd_q    <= 1'b0;
         fwd_rd_q <= '0;
      end else begin
         fwd_q    <= fwd_d;
         fwd_rd_q <= fwd_rd_d;
      end
   end
`else
   assign instr_ready = rst_n && (state_q == ST_IDLE);
   assign opnd1_s     = rdata1_s;
   assign opnd2_s     = rdata2_s;
`endif

   assign hs_s    = instr_valid && instr_ready;
   assign eq_flag = eq_q;

   alu_issue_regfile #(
      .DATA_W     (DATA_W),
      .REG_ADDR_W (REG_ADDR_W)
   ) u_regfile (
      .clk        (clk),
      .rst_n      (rst_n),
      .we_i       (we_s),
      .waddr_i    (rd_s),
      .wdata_i    (res_q),
      .raddr1_i   (rs1_s),
      .raddr2_i   (rs2_s),
      .dbg_addr_i (dbg_addr),
      .rdata1_o   (rdata1_s),
      .rdata2_o   (rdata2_s),
      .dbg_data_o (dbg_data)
   );

   // Next-state, ALU drive and write-back decode.
   always_comb begin
      state_d      = state_q;
      instr_d      = instr_q;
      res_d        = res_q;
      zq_d         = zq_q;
      eq_d         = eq_q;
      alu_op       = IDLE_OP;
      alu_operand1 = '0;
      alu_operand2 = '0;
      wb_valid     = 1'b0;
      wb_addr      = '0;
      wb_data      = '0;
      illegal_op   = 1'b0;
      we_s         = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (hs_s) begin
               instr_d = instr;
               state_d = ST_EXEC;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_EXEC: begin
            alu_op       = op_s;
            alu_operand1 = opnd1_s;
            alu_operand2 = opnd2_s;
            res_d        = (op_s == OP_LDI) ? imm_s : alu_result;
            zq_d         = alu_zero;
            state_d      = ST_WB;
         end
         ST_WB: begin
            wb_valid = 1'b1;
            wb_addr  = rd_s;
            if (op_writes_reg(op_s)) begin
               we_s    = 1'b1;
               wb_data = res_q;
            end else if (op_s == OP_CMP) begin
               eq_d = zq_q;
            end else begin
               illegal_op = 1'b1;
            end
`ifdef ALU_ISSUE_OVERLAP_EN
            if (hs_s) begin
               instr_d = instr;
               state_d = ST_EXEC;
            end else begin
               state_d = ST_IDLE;
            end
`else
            state_d = ST_IDLE;
`endif
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Control and datapath state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         instr_q <= '0;
         res_q   <= '0;
         zq_q    <= 1'b0;
         eq_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         instr_q <= instr_d;
         res_q   <= res_d;
         zq_q    <= zq_d;
         eq_q    <= eq_d;
      end
   end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with a behavioural ALU and reference register model.
module tb_alu_issue_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        instr_valid;
   logic        instr_ready;
   logic [15:0] instr;
   logic [7:0]  alu_operand1, alu_operand2, alu_result;
   logic [3:0]  alu_op;
   logic        alu_zero;
   logic        wb_valid;
   logic [1:0]  wb_addr;
   logic [7:0]  wb_data;
   logic        eq_flag;
   logic        illegal_op;
   logic [1:0]  dbg_addr;
   logic [7:0]  dbg_data;

   int          checks = 0;
   int          errors = 0;
   logic [7:0]  ref_reg [4];
   logic        ref_eq;

   always #5 clk = ~clk;

   alu_issue_ctrl dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .instr_valid  (instr_valid),
      .instr_ready  (instr_ready),
      .instr        (instr),
      .alu_operand1 (alu_operand1),
      .alu_operand2 (alu_operand2),
      .alu_op       (alu_op),
      .alu_result   (alu_result),
      .alu_zero     (alu_zero),
      .wb_valid     (wb_valid),
      .wb_addr      (wb_addr),
      .wb_data      (wb_data),
      .eq_flag      (eq_flag),
      .illegal_op   (illegal_op),
      .dbg_addr     (dbg_addr),
      .dbg_data     (dbg_data)
   );

   // Combinational 8-bit ALU the controller drives.
   always_comb begin
      alu_result = 8'h00;
      case (alu_op)
         4'h0: alu_result = alu_operand1 + alu_operand2;
         4'h1: alu_result = alu_operand1 - alu_operand2;
         4'h2: alu_result = alu_operand1 + 8'h01;
         4'h3: alu_result = alu_operand1 - 8'h01;
         4'h4: alu_result = alu_operand1 & alu_operand2;
         4'h5: alu_result = alu_operand1 | alu_operand2;
         4'h6: alu_result = alu_operand1 ^ alu_operand2;
         4'h7: alu_result = alu_operand1 << 1;
         4'h8: alu_result = alu_operand1 >> 1;
         4'h9: alu_result = alu_operand1 - alu_operand2;
         default: alu_result = 8'h00;
      endcase
      alu_zero = (alu_result == 8'h00);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] model_result(input int op, input int a, input int b, input int imm);
      int r;
      case (op)
         0:  r = a + b;
         1:  r = a - b + 256;
         2:  r = a + 1;
         3:  r = a + 255;
         4:  r = a & b;
         5:  r = a | b;
         6:  r = a ^ b;
         7:  r = a * 2;
         8:  r = a / 2;
         10: r = imm;
         default: r = 0;
      endcase
      r = r % 256;
      return 8'(r);
   endfunction

   task automatic chk_regs(input string tag);
      for (int i = 0; i < 4; i++) begin
         dbg_addr = 2'(i);
         #1;
         chk(tag, dbg_data, ref_reg[i]);
      end
   endtask

   // One full instruction: offer, check EXEC drive, check WB, update model.
   task automatic do_instr(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs1, input logic [7:0] low);
      logic [7:0] a, b, exp_data;
      logic       writes, ill;
      int         n;
      a        = ref_reg[rs1];
      b        = ref_reg[low[7:6]];
      writes   = (op <= 4'h8) || (op == 4'hA);
      ill      = (op >= 4'hB);
      exp_data = writes ? model_result(int'(op), int'(a), int'(b), int'(low)) : 8'h00;
      dbg_addr = rd;
      @(negedge clk);
      instr       = {op, rd, rs1, low};
      instr_valid = 1'b1;
      n = 0;
      while (!instr_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("accept", instr_ready, 32'd1);
      @(negedge clk);
      instr_valid = 1'b0;
      chk("exec_op", alu_op, op);
      chk("exec_opnd1", alu_operand1, a);
      chk("exec_opnd2", alu_operand2, b);
      chk("exec_ready", instr_ready, 32'd0);
      chk("exec_wb_idle", wb_valid, 32'd0);
      @(negedge clk);
      chk("wb_valid", wb_valid, 32'd1);
      chk("wb_addr", wb_addr, rd);
      chk("wb_data", wb_data, exp_data);
      chk("illegal_op", illegal_op, ill);
      chk("dbg_prewrite", dbg_data, ref_reg[rd]);
      if (writes) ref_reg[rd] = exp_data;
      if (op == 4'h9) ref_eq = (a == b);
      @(negedge clk);
      chk("wb_pulse_end", wb_valid, 32'd0);
      chk("eq_flag", eq_flag, ref_eq);
      chk("dbg_postwrite", dbg_data, ref_reg[rd]);
   endtask

   initial begin
      int hs, wbc, bad, exp_hs;
      rst_n       = 1'b0;
      instr_valid = 1'b0;
      instr       = 16'h0000;
      dbg_addr    = 2'd0;
      for (int i = 0; i < 4; i++) ref_reg[i] = 8'h00;
      ref_eq = 1'b0;

      #12;
      chk("rst_ready", instr_ready, 32'd0);
      chk("rst_alu_op", alu_op, 32'hF);
      chk("rst_opnd1", alu_operand1, 32'd0);
      chk("rst_opnd2", alu_operand2, 32'd0);
      chk("rst_wb_valid", wb_valid, 32'd0);
      chk("rst_eq", eq_flag, 32'd0);
      chk("rst_illegal", illegal_op, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      chk_regs("rst_regs");

      // LDI / ADD basics
      do_instr(4'hA, 2'd1, 2'd0, 8'h05);
      do_instr(4'hA, 2'd2, 2'd0, 8'h03);
      do_instr(4'h0, 2'd3, 2'd1, 8'h80);
      // wrap and shifts
      do_instr(4'hA, 2'd0, 2'd0, 8'hFF);
      do_instr(4'h2, 2'd1, 2'd0, 8'h00);
      do_instr(4'h7, 2'd2, 2'd0, 8'h00);
      do_instr(4'hA, 2'd3, 2'd0, 8'h81);
      do_instr(4'h8, 2'd3, 2'd3, 8'h00);
      chk_regs("wrap_shift_regs");
      // CMP equal, unaffected by ADD, then not-equal
      do_instr(4'hA, 2'd1, 2'd0, 8'h07);
      do_instr(4'hA, 2'd2, 2'd0, 8'h07);
      do_instr(4'h9, 2'd0, 2'd1, 8'h80);
      chk_regs("cmp_regs");
      do_instr(4'h0, 2'd3, 2'd1, 8'h80);
      do_instr(4'hA, 2'd2, 2'd0, 8'h06);
      do_instr(4'h9, 2'd0, 2'd1, 8'h80);
      // illegal opcode, then normal
      do_instr(4'hC, 2'd1, 2'd2, 8'h40);
      chk_regs("illegal_regs");
      do_instr(4'h6, 2'd0, 2'd1, 8'h80);

      // Backpressure: valid held continuously with INC r3
`ifdef ALU_ISSUE_OVERLAP_EN
      exp_hs = 5;
`else
      exp_hs = 3;
`endif
      hs = 0; wbc = 0; bad = 0;
      @(negedge clk);
      instr       = {4'h2, 2'd3, 2'd3, 8'h00};
      instr_valid = 1'b1;
      for (int i = 0; i < 9; i++) begin
         if (instr_ready) hs++;
         if (wb_valid) wbc++;
         if (instr_ready && alu_op == 4'h2) bad++;
         @(negedge clk);
      end
      instr_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (wb_valid) wbc++;
         @(negedge clk);
      end
      chk("bp_handshakes", hs, exp_hs);
      chk("bp_wb_pulses", wbc, exp_hs);
      chk("bp_ready_in_exec", bad, 32'd0);
      ref_reg[3] = model_result(0, int'(ref_reg[3]), exp_hs, 0);
      chk_regs("bp_regs");

      // Randomized instruction stream
      for (int k = 0; k < 40; k++) begin
         do_instr(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
         if (k % 10 == 9) chk_regs("rand_regs");
      end

`ifdef ALU_ISSUE_OVERLAP_EN
      // Back-to-back LDI r1 then ADD r2,r1,r1 with acceptance in WB
      @(negedge clk);
      instr       = {4'hA, 2'd1, 2'd0, 8'h10};
      instr_valid = 1'b1;
      @(negedge clk);
      instr = {4'h0, 2'd2, 2'd1, 8'h40};
      @(negedge clk);
      chk("ov_wb1_valid", wb_valid, 32'd1);
      chk("ov_wb1_data", wb_data, 32'h10);
      chk("ov_ready_wb", instr_ready, 32'd1);
      @(negedge clk);
      instr_valid = 1'b0;
      chk("ov_fwd_opnd1", alu_operand1, 32'h10);
      chk("ov_fwd_opnd2", alu_operand2, 32'h10);
      @(negedge clk);
      chk("ov_wb2_valid", wb_valid, 32'd1);
      chk("ov_wb2_data", wb_data, 32'h20);
      ref_reg[1] = 8'h10;
      ref_reg[2] = 8'h20;
      @(negedge clk);
      chk_regs("ov_regs");
`endif

      // Reset during EXEC: instruction lost, regfile cleared
      @(negedge clk);
      instr       = {4'hA, 2'd0, 2'd0, 8'h55};
      instr_valid = 1'b1;
      @(negedge clk);
      instr_valid = 1'b0;
      chk("mid_exec_op", alu_op, 32'hA);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ready", instr_ready, 32'd0);
      chk("mid_rst_alu_op", alu_op, 32'hF);
      wbc = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (wb_valid) wbc++;
      end
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (wb_valid) wbc++;
      end
      chk("mid_rst_no_wb", wbc, 32'd0);
      for (int i = 0; i < 4; i++) ref_reg[i] = 8'h00;
      ref_eq = 1'b0;
      chk("mid_rst_eq", eq_flag, 32'd0);
      chk_regs("mid_rst_regs");
      do_instr(4'hA, 2'd2, 2'd0, 8'h3C);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Control-side counterpart of the 8-bit ALU: decodes an instruction stream and owns a small register file.
- Drives the ALU operand and opcode inputs, then samples the ALU result and equality flag.
- Writes results back and reports each retired instruction.
- Sits between the instruction source (valid/ready) and the combinational ALU.

Parameters:
- DATA_W, 8, operand/result/register width; must equal ALU width.
- REG_ADDR_W, 2, register address width; register file has 2**REG_ADDR_W entries.
- IDLE_OP, 4'hF, opcode driven to ALU when not executing; any ALU-default opcode (ALU outputs 0).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- instr_valid  in  1  instruction offered
- instr_ready  out  1  controller accepts the instruction this cycle
- instr  in  INSTR_W=4+2*REG_ADDR_W+DATA_W (16)  fields, MSB first: [15:12] op, [11:10] rd, [9:8] rs1, [7:0] low field (rs2=[7:6], imm=[7:0])
- alu_operand1  out  DATA_W  to ALU operand1
- alu_operand2  out  DATA_W  to ALU operand2
- alu_op  out  4  to ALU opCode
- alu_result  in  DATA_W  from ALU result
- alu_zero  in  1  from ALU zero_flag
- wb_valid  out  1  one-cycle pulse per retired instruction
- wb_addr  out  REG_ADDR_W  destination written (valid with wb_valid)
- wb_data  out  DATA_W  value written (valid with wb_valid)
- eq_flag  out  1  registered result of the last CMP
- illegal_op  out  1  one-cycle pulse with wb_valid for opcodes 0xB-0xF
- dbg_addr  in  REG_ADDR_W  debug read address
- dbg_data  out  DATA_W  combinational read of regfile[dbg_addr]

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all registers, wb_*, eq_flag, illegal_op = 0.
  - alu_op=IDLE_OP; operands=0; instr_ready=0 while rst_n=0.
- FSM IDLE -> EXEC -> WB -> IDLE. Throughput is 1 instruction per 3 cycles without the optional feature.
- IDLE:
  - instr_ready=1.
  - On instr_valid&&instr_ready: capture instr into instr_q and go to EXEC.
  - No capture otherwise; alu_op=IDLE_OP.
- EXEC:
  - alu_op=instr_q.op.
  - alu_operand1=reg[rs1]; alu_operand2=reg[rs2].
  - At the clock edge: res_q<=alu_result, zq<=alu_zero. Go to WB.
  - Ops 0-8 use res_q. Op 9 (CMP) uses zq only. Op 0xA (LDI) ignores the ALU; res_q<=imm.
- WB, one cycle:
  - wb_valid=1 and wb_addr=rd.
  - Ops 0-8 and 0xA: reg[rd]<=res_q; wb_data=res_q.
  - Op 9: eq_flag<=zq; no register write; wb_data=0.
  - Ops 0xB-0xF: no write; illegal_op=1; wb_data=0.
  - Next state is IDLE.
- Arithmetic is modulo 2**DATA_W; no carry or overflow is kept (e.g. 0xFF+0x01=0x00).
- eq_flag is only ever changed by CMP; other ops leave it unchanged.
- ALU outputs are sampled only in EXEC; values in any other state are ignored.
- instr must be held stable while instr_valid=1 && instr_ready=0 (source rule). The controller captures exactly once per handshake.
- Reset mid-instruction: the instruction is lost, no wb_valid is emitted, and the register file returns to 0.
- dbg_data is a pure combinational read. In the WB cycle it shows the pre-write value.

Optional Feature:
- Macro ALU_ISSUE_OVERLAP_EN.
- When defined:
  - instr_ready=1 in WB as well as IDLE. A handshake in WB goes directly to EXEC, giving 1 instruction per 2 cycles.
  - In the following EXEC, an operand whose rs equals the previous rd, where the previous op wrote a register, is forwarded from the written value, not the stale register.
- When undefined: instr_ready is high only in IDLE and no forwarding logic exists.

Decomposition:
- Package alu_issue_pkg holds:
  - Opcode constants OP_ADD=0, OP_SUB=1, OP_INC=2, OP_DEC=3, OP_AND=4, OP_OR=5, OP_XOR=6, OP_SHL=7, OP_SHR=8, OP_CMP=9, OP_LDI=4'hA.
  - FSM state encoding.
  - Instruction field offset constants.
- One natural sub-module: alu_issue_regfile (2**REG_ADDR_W x DATA_W, async reset, 1 write port, 3 combinational read ports: rs1, rs2, dbg).

Test Plan:
- Reset release, then LDI r1,0x05; LDI r2,0x03; ADD r3,r1,r2 -> wb pulses (1,0x05), (2,0x03), (3,0x08); alu_op=0 during ADD EXEC; dbg_addr=3 gives dbg_data=0x08.
- LDI r0,0xFF; INC r1,r0; SHL r2,r0 -> r1=0x00 (wrap), r2=0xFE; SHR of 0x81 gives 0x40.
- CMP r1,r2 with both 0x07 -> eq_flag=1, no register changes; CMP with 0x07 vs 0x06 -> eq_flag=0; subsequent ADD leaves eq_flag unchanged.
- Opcode 0xC -> illegal_op and wb_valid pulse together; all registers unchanged; next instruction accepted normally.
- Backpressure: instr_valid held continuously -> instr_ready high only in IDLE, one capture per handshake, no duplicate wb_valid. Assert rst_n=0 during EXEC -> no wb_valid; all registers read 0.
- With ALU_ISSUE_OVERLAP_EN: back-to-back LDI r1,0x10; ADD r2,r1,r1 -> second instruction accepted in WB; r2=0x20 via forwarding; 2-cycle spacing between wb_valid pulses.
